// File: rtl/aes_inv_cipher_ctrl.sv
// aes_inv_cipher_ctrl: AES-128 inverse cipher sequencer owning the state register and round-key fetch
module aes_inv_cipher_ctrl (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [127:0] cipher_in,
  output logic         ready,
  output logic         key_req,
  output logic [3:0]   key_addr,
  input  logic         key_ack,
  input  logic [127:0] key_data,
  output logic [127:0] dp_in,
  input  logic [127:0] dp_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plain_out
);
  typedef enum logic [2:0] {IDLE, WHITEN, ROUND, FINAL, DONE} st_t;
  st_t          st_q, st_d;
  logic [127:0] state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] b, m2, m4, m8;
    logic [7:0] x9 [4];
    logic [7:0] xb [4];
    logic [7:0] xd [4];
    logic [7:0] xe [4];
    for (int i = 0; i < 4; i++) begin
      b     = c[31-8*i -: 8];
      m2    = xt(b);
      m4    = xt(m2);
      m8    = xt(m4);
      x9[i] = m8 ^ b;
      xb[i] = m8 ^ m2 ^ b;
      xd[i] = m8 ^ m4 ^ b;
      xe[i] = m8 ^ m4 ^ m2;
    end
    return {xe[0] ^ xb[1] ^ xd[2] ^ x9[3],
            x9[0] ^ xe[1] ^ xb[2] ^ xd[3],
            xd[0] ^ x9[1] ^ xe[2] ^ xb[3],
            xb[0] ^ xd[1] ^ x9[2] ^ xe[3]};
  endfunction
  function automatic logic [127:0] inv_mix128(input logic [127:0] s);
    return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]), inv_mix_col(s[63:32]), inv_mix_col(s[31:0])};
  endfunction
  assign ready     = st_q == IDLE;
  assign key_req   = st_q == WHITEN || st_q == ROUND || st_q == FINAL;
  assign key_addr  = st_q == WHITEN ? 4'd10 : st_q == ROUND ? rnd_q : 4'd0;
  assign out_valid = st_q == DONE;
  assign plain_out = out_valid ? state_q : '0;
  assign dp_in     = state_q;
  always_comb begin
    st_d    = st_q;
    state_d = state_q;
    rnd_d   = rnd_q;
    case (st_q)
      IDLE: if (start) begin
        state_d = cipher_in;
        st_d    = WHITEN;
      end
      WHITEN: if (key_ack) begin
        state_d = state_q ^ key_data;
        rnd_d   = 4'd9;
        st_d    = ROUND;
      end
      ROUND: if (key_ack) begin
        state_d = inv_mix128(dp_out ^ key_data);
        rnd_d   = rnd_q == 4'd1 ? rnd_q : rnd_q - 4'd1;
        st_d    = rnd_q == 4'd1 ? FINAL : ROUND;
      end
      FINAL: if (key_ack) begin
        state_d = dp_out ^ key_data;
        st_d    = DONE;
      end
      DONE: st_d = out_ready ? IDLE : DONE;
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      st_q    <= IDLE;
      state_q <= '0;
      rnd_q   <= '0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      rnd_q   <= rnd_d;
    end
  end
endmodule
